i2s_slave_rx: RTL and testbench
===============================

# i2s_slave_rx

I2S slave receiver: deserializes an I2S stream whose bit clock and word select come from outside, clocked entirely by the I2S master clock. It sits on the far end of the master `io_module` link, on the `da_sclk`/`da_lrck`/`da_sdin` lines or an equivalent external source. It returns parallel left/right samples with a frame-valid pulse. Used for loopback self-test of the audio path and for accepting audio from slave-mode sources.

## Interface
Parameters:
- `d_width`, 24, captured sample width, MSB first
- `sclk_ws_ratio`, 64, expected sclk periods per ws period; must be even and ≥ 2·d_width+2
- `mclk_sclk_ratio`, 4, minimum mclk periods per sclk period; must be ≥ 4

Ports:
- `mclk`  in  1  master clock, sole clock
- `reset_n`  in  1  synchronous, active-low reset
- `sclk`  in  1  asynchronous bit clock
- `ws`  in  1  asynchronous word select: 0 = left, 1 = right
- `sd`  in  1  asynchronous serial data
- `l_data_rx`  out  d_width  last complete left sample, signed
- `r_data_rx`  out  d_width  last complete right sample, signed
- `o_dv`  out  1  one-mclk pulse when the l/r pair updates
- `o_frame_err`  out  1  one-mclk pulse on framing violation
- `o_locked`  out  1  high once the first ws transition has been seen

## Operation
- **Synchronizers.** `sclk`, `ws` and `sd` each pass through a two-flop synchronizer with identical depth. A third `sclk` flop holds the previous level. A sclk rise is detected when the synchronized level is 1 and the previous level is 0.
- **Per-rise sampling.** On each detected rise, sample synchronized `ws` and `sd`. Compare `ws` with the ws value from the previous rise (`ws_prev`).
- **Transition rise** (`ws` ≠ `ws_prev`):
  - The bit on `sd` is the previous word's trailing slot. It is ignored.
  - `bit_cnt` ← 0. `chan` ← `ws`.
  - If `o_locked` = 1 and `slot_cnt + 1` ≠ `sclk_ws_ratio`/2, pulse `o_frame_err`.
  - `slot_cnt` ← 0. `o_locked` ← 1.
- **Non-transition rise:**
  - `slot_cnt` increments and saturates at its maximum.
  - If `o_locked` and `bit_cnt` < `d_width`: `shreg` ← {`shreg`[d_width-2:0], `sd`} and `bit_cnt`++.
  - Bits after `d_width` are ignored; `bit_cnt` saturates at `d_width`.
- **Word complete.** A word is complete on the rise where `bit_cnt` becomes `d_width`.
  - `chan` = 0: store the word in `l_hold` and set `l_ok`.
  - `chan` = 1 with `l_ok` = 1: on the next mclk, `l_data_rx` ← `l_hold`, `r_data_rx` ← word, `o_dv` pulses, `l_ok` clears.
  - `chan` = 1 with `l_ok` = 0: word discarded, no `o_dv`.
- **Short word.** A ws transition with `bit_cnt` < `d_width` in a locked state is a short word.
  - The partial word is discarded and `l_ok` clears.
  - `o_frame_err` pulses, counted as one event together with any slot-count error.
- **States:**
  - UNLOCKED: after reset, until the first ws transition.
  - LOCKED: permanent until reset.
  - Data before the first transition is discarded.
- **Width rules:**
  - `bit_cnt` is $clog2(d_width+1) bits.
  - `slot_cnt` is $clog2(sclk_ws_ratio) bits.
  - Outputs carry the raw received bits with no sign extension or truncation.
- **Simultaneous events:** a transition rise that also ends a short word gives one `o_frame_err` pulse, not two.

## Timing
- **Reset:**
  - `reset_n` = 0 sampled on a `mclk` edge clears, on that edge, `l_data_rx`, `r_data_rx`, `o_dv`, `o_frame_err`, `o_locked`, all counters, `shreg`, `l_hold`, `l_ok`, `ws_prev` and the synchronizers.
  - A mid-word reset discards everything. Lock must be re-acquired.
- **Latency:** `o_dv` rises exactly 4 mclk edges after the first mclk edge that samples `sclk` high on the right-word LSB rise. The 4 edges are 2 synchronizer edges, 1 edge-detect/shift edge and 1 output-register edge.
- `o_dv` and `o_frame_err` are high for exactly one mclk.
- `l_data_rx`/`r_data_rx` change only in the cycle `o_dv` = 1 and are stable otherwise.
- **Frame rate:** at the default ratios, `o_dv` period is 256 mclk.
- No backpressure: consumers must sample on `o_dv`.

## Test plan
Bench BFM: I2S master, sclk = mclk/4, 64 sclk per frame, data changes on falling sclk, ws one bit ahead of MSB.

1. **Reset.** Hold `reset_n` = 0 for 5 mclk with the BFM toggling → all outputs 0. `o_locked` stays 0 until the first ws edge.
2. **Basic pair.** ws idles at 1, then the BFM sends L = 0x123456, R = 0xABCDEF → `o_locked` = 1; one `o_dv` with `l_data_rx` = 0x123456, `r_data_rx` = 0xABCDEF; no `o_frame_err`; latency exactly 4 mclk after the LSB sclk rise.
3. **Extremes, 4 consecutive frames.** Pairs (0x800000, 0x7FFFFF), (0xFFFFFF, 0x000001), (0x000000, 0xFFFFFF), (0x555555, 0xAAAAAA) → 4 `o_dv` pulses spaced exactly 256 mclk, with bit-exact data.
4. **Short left word.** ws toggles after 20 sclk in the left half → one `o_frame_err` pulse; no `o_dv` for that frame; the next correct frame (0x0F0F0F, 0xF0F0F0) produces `o_dv` with those values.
5. **Long frame.** Left half of 34 sclk → `o_frame_err` pulse at the right transition; data for that frame is still delivered with `o_dv`.
6. **Reset mid-word.** `reset_n` = 0 for 1 mclk in the middle of the left word → outputs 0 and `o_locked` = 0 next cycle. The first `o_dv` afterwards comes only after a new ws transition and a full left+right pair.

Source files
------------

// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: I2S slave receiver clocked by mclk; syncs sclk/ws/sd, deserializes
// MSB-first words and emits left/right pairs with a frame-valid pulse.
module i2s_slave_rx #(
  parameter int d_width         = 24,
  parameter int sclk_ws_ratio   = 64,
  parameter int mclk_sclk_ratio = 4
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic               sclk,
  input  logic               ws,
  input  logic               sd,
  output logic [d_width-1:0] l_data_rx,
  output logic [d_width-1:0] r_data_rx,
  output logic               o_dv,
  output logic               o_frame_err,
  output logic               o_locked
);
  localparam int bw = $clog2(d_width + 1);
  localparam int sw = $clog2(sclk_ws_ratio);

  if (mclk_sclk_ratio < 4 || sclk_ws_ratio % 2 != 0 || sclk_ws_ratio < 2 * d_width + 2) begin : g_bad_params
    $error("i2s_slave_rx: illegal parameter combination");
  end

  logic [1:0]         sclk_s, ws_s, sd_s;
  logic               sclk_d, ws_prev, ws_vld, chan, l_ok, r_done;
  logic [bw-1:0]      bit_cnt;
  logic [sw-1:0]      slot_cnt;
  logic [d_width-1:0] shreg, shreg_nx, l_hold;
  logic               rise, trans, full, done, slot_ok;

  always_comb begin
    rise     = sclk_s[1] & ~sclk_d;
    trans    = ws_vld & (ws_s[1] != ws_prev);
    shreg_nx = {shreg[d_width-2:0], sd_s[1]};
    full     = bit_cnt == bw'(d_width);
    done     = rise & ~trans & o_locked & (bit_cnt == bw'(d_width - 1));
    slot_ok  = int'(slot_cnt) + 1 == sclk_ws_ratio / 2;
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      sclk_s      <= '0;
      ws_s        <= '0;
      sd_s        <= '0;
      sclk_d      <= 1'b0;
      ws_prev     <= 1'b0;
      ws_vld      <= 1'b0;
      chan        <= 1'b0;
      l_ok        <= 1'b0;
      r_done      <= 1'b0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      shreg       <= '0;
      l_hold      <= '0;
      l_data_rx   <= '0;
      r_data_rx   <= '0;
      o_dv        <= 1'b0;
      o_frame_err <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      sclk_s      <= {sclk_s[0], sclk};
      ws_s        <= {ws_s[0], ws};
      sd_s        <= {sd_s[0], sd};
      sclk_d      <= sclk_s[1];
      o_dv        <= r_done;
      o_frame_err <= 1'b0;
      r_done      <= 1'b0;
      if (r_done) begin
        l_data_rx <= l_hold;
        r_data_rx <= shreg;
        l_ok      <= 1'b0;
      end
      if (rise) begin
        // the first rise after reset only seeds ws_prev, so an idle ws level never reads as an edge
        ws_prev <= ws_s[1];
        ws_vld  <= 1'b1;
        if (trans) begin
          bit_cnt  <= '0;
          slot_cnt <= '0;
          chan     <= ws_s[1];
          o_locked <= 1'b1;
          if (o_locked && (!slot_ok || !full)) o_frame_err <= 1'b1;
          if (o_locked && !full) l_ok <= 1'b0;
        end else begin
          if (slot_cnt != '1) slot_cnt <= slot_cnt + 1'b1;
          if (o_locked && !full) begin
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (done && !chan) begin
            l_hold <= shreg_nx;
            l_ok   <= 1'b1;
          end
          if (done && chan && l_ok) r_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: I2S master BFM (sclk = mclk/4) with a frame-level model of the
// receiver checked every cycle, plus literal checks on pairs, latency and spacing.
module tb_i2s_slave_rx;
  localparam int INF = 32'h7fff_ffff;

  logic        mclk = 1'b0, reset_n = 1'b0, sclk = 1'b0, ws = 1'b1, sd = 1'b0;
  logic [23:0] l_data_rx, r_data_rx;
  logic        o_dv, o_frame_err, o_locked;

  i2s_slave_rx dut (
    .mclk(mclk), .reset_n(reset_n), .sclk(sclk), .ws(ws), .sd(sd),
    .l_data_rx(l_data_rx), .r_data_rx(r_data_rx),
    .o_dv(o_dv), .o_frame_err(o_frame_err), .o_locked(o_locked)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [23:0] l;
    logic [23:0] r;
  } ev_t;

  ev_t         dvq[$], obs[$];
  int          errq[$], err_obs[$];
  int          checks = 0, errors = 0;
  int          lock_at = INF;
  logic [23:0] exp_l = '0, exp_r = '0;
  logic        e_dv, e_err, e_lock;
  bit          done = 1'b0;

  bit          m_seen = 1'b0, m_locked = 1'b0, m_half_locked = 1'b0, m_lok = 1'b0, m_ws = 1'b1;
  logic [23:0] m_lhold = '0;
  int          m_len = 32, last_lsb = 0, lsb0 = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 1'b0; m_locked = 1'b0; m_half_locked = 1'b0; m_lok = 1'b0;
    lock_at = INF; dvq.delete(); errq.delete(); exp_l = '0; exp_r = '0;
  endtask

  // one ws half of n sclk periods; slot 0 carries the previous word's trailing bit
  task automatic half(input bit wsv, input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; ws = wsv; sd = (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
      @(negedge mclk); @(negedge mclk);
      sclk = 1'b1;
      if (i == 0 && m_seen && wsv != m_ws) begin
        if (m_locked && m_len != 32) errq.push_back(cyc + 3);
        if (m_locked && m_len < 25) m_lok = 1'b0;
        if (!m_locked) lock_at = cyc + 3;
        m_locked = 1'b1; m_half_locked = 1'b1;
      end
      if (reset_n) m_seen = 1'b1;
      m_ws = wsv;
      if (i == 24 && m_half_locked) begin
        if (!wsv) begin
          m_lok = 1'b1; m_lhold = w;
        end else if (m_lok) begin
          dvq.push_back('{c: cyc + 4, l: m_lhold, r: w});
          m_lok = 1'b0; last_lsb = cyc;
        end
      end
      @(negedge mclk); @(negedge mclk);
    end
    m_len = n;
  endtask

  always @(negedge mclk) begin
    if (cyc >= 1 && !done) begin
      while (dvq.size() > 0 && dvq[0].c < cyc) void'(dvq.pop_front());
      while (errq.size() > 0 && errq[0] < cyc) void'(errq.pop_front());
      e_dv = dvq.size() > 0 && dvq[0].c == cyc;
      if (e_dv) begin
        exp_l = dvq[0].l; exp_r = dvq[0].r; void'(dvq.pop_front());
      end
      e_err = errq.size() > 0 && errq[0] == cyc;
      if (e_err) void'(errq.pop_front());
      e_lock = cyc >= lock_at;
      checks++;
      if ({o_dv, o_frame_err, o_locked, l_data_rx, r_data_rx} !== {e_dv, e_err, e_lock, exp_l, exp_r}) begin
        errors++;
        $display("FAIL cycle %0d dv/err/lock/l/r: got %b %b %b %h %h expected %b %b %b %h %h",
                 cyc, o_dv, o_frame_err, o_locked, l_data_rx, r_data_rx, e_dv, e_err, e_lock, exp_l, exp_r);
      end
      if (o_dv === 1'b1) obs.push_back('{c: cyc, l: l_data_rx, r: r_data_rx});
      if (o_frame_err === 1'b1) err_obs.push_back(cyc);
    end
  end

  logic [23:0] exp_pairs [8][2] = '{
    '{24'h123456, 24'hABCDEF}, '{24'h800000, 24'h7FFFFF}, '{24'hFFFFFF, 24'h000001},
    '{24'h000000, 24'hFFFFFF}, '{24'h555555, 24'hAAAAAA}, '{24'h0F0F0F, 24'hF0F0F0},
    '{24'h13579B, 24'h2468AC}, '{24'h777777, 24'h888888}};

  initial begin
    @(negedge mclk);
    // reset held for 5 mclk while the BFM idles with ws = 1
    fork
      half(1'b1, 24'h0, 32);
      begin
        repeat (4) @(posedge mclk);
        #1;
        chk("reset_locked", o_locked, 0);
        chk("reset_dv_err", {o_dv, o_frame_err}, 0);
        chk("reset_l", l_data_rx, 0);
        chk("reset_r", r_data_rx, 0);
        @(negedge mclk);
        reset_n = 1'b1;
      end
    join
    chk("unlocked_before_edge", o_locked, 0);
    half(1'b0, 24'h123456, 32);
    chk("locked_after_edge", o_locked, 1);
    half(1'b1, 24'hABCDEF, 32);
    lsb0 = last_lsb;
    for (int f = 1; f <= 4; f++) begin
      half(1'b0, exp_pairs[f][0], 32);
      half(1'b1, exp_pairs[f][1], 32);
    end
    half(1'b0, 24'hDEAD00, 20);
    half(1'b1, 24'h999999, 32);
    half(1'b0, 24'h0F0F0F, 32);
    half(1'b1, 24'hF0F0F0, 32);
    half(1'b0, 24'h13579B, 34);
    half(1'b1, 24'h2468AC, 32);
    fork
      half(1'b0, 24'h111111, 32);
      begin
        repeat (41) @(negedge mclk);
        reset_n = 1'b0;
        @(posedge mclk);
        #1;
        model_reset();
        chk("midreset_locked", o_locked, 0);
        chk("midreset_l", l_data_rx, 0);
        chk("midreset_r", r_data_rx, 0);
        @(negedge mclk);
        reset_n = 1'b1;
      end
    join
    half(1'b1, 24'h222222, 32);
    half(1'b0, 24'h777777, 32);
    half(1'b1, 24'h888888, 32);
    half(1'b0, 24'h000000, 32);
    repeat (8) @(negedge mclk);
    done = 1'b1;
    chk("dv_count", obs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs.size()) begin
        chk($sformatf("pair%0d_l", i), obs[i].l, exp_pairs[i][0]);
        chk($sformatf("pair%0d_r", i), obs[i].r, exp_pairs[i][1]);
      end
    end
    if (obs.size() > 0) chk("dv_latency", obs[0].c - lsb0, 4);
    for (int i = 1; i <= 4; i++)
      if (i < obs.size()) chk($sformatf("dv_spacing%0d", i), obs[i].c - obs[i-1].c, 256);
    chk("frame_err_count", err_obs.size(), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
